// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: IDU instruction, address sources, T-cycles and bus bundles.
// Imported by the bus controller and its address mux.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    IDU_NOP  = 2'd0,
    IDU_INC  = 2'd1,
    IDU_DEC  = 2'd2,
    IDU_PASS = 2'd3
  } idu_opcode_t;

  typedef struct packed {
    idu_opcode_t opcode;
    logic [15:0] operand;
  } idu_instruction_t;

  typedef enum logic [2:0] {
    ADDR_PC  = 3'd0,
    ADDR_SP  = 3'd1,
    ADDR_HL  = 3'd2,
    ADDR_BC  = 3'd3,
    ADDR_DE  = 3'd4,
    ADDR_WZ  = 3'd5,
    ADDR_FFC = 3'd6,
    ADDR_FFZ = 3'd7
  } addr_src_t;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } tcycle_t;

  typedef struct packed {
    logic        valid;
    addr_src_t   addr_sel;
    idu_opcode_t idu_op;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic        wb_en;
    addr_src_t   wb_dst;
  } bus_req_t;

  typedef struct packed {
    logic [15:0] addr;
    idu_opcode_t op;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic        wb_en;
    addr_src_t   wb_dst;
    logic        lock;
  } mcycle_t;

  localparam mcycle_t MC_RESET = '{
    addr:   16'h0000,
    op:     IDU_NOP,
    rd:     1'b0,
    wr:     1'b0,
    wdata:  8'h00,
    wb_en:  1'b0,
    wb_dst: ADDR_PC,
    lock:   1'b0
  };

  localparam logic [15:0] HRAM_BASE = 16'hFF80;

  function automatic logic is_ff_page(input addr_src_t s);
    return (s == ADDR_FFC) || (s == ADDR_FFZ);
  endfunction

endpackage

// File: rtl/gb_cpu_addr_mux.sv
// Selects the M-cycle address from register pairs, FF-page forms or
// the writeback bypass when the previous cycle is updating that pair.
module gb_cpu_addr_mux
  import gb_cpu_common_pkg::*;
(
  input  addr_src_t   sel,
  input  logic [15:0] reg_pc,
  input  logic [15:0] reg_sp,
  input  logic [15:0] reg_hl,
  input  logic [15:0] reg_bc,
  input  logic [15:0] reg_de,
  input  logic [15:0] reg_wz,
  input  logic        byp_valid,
  input  addr_src_t   byp_dst,
  input  logic [15:0] byp_data,
  output logic [15:0] addr
);

  logic [15:0] base;

  // Raw source selection from the register file view
  always_comb begin
    base = 16'h0000;
    unique case (sel)
      ADDR_PC:  base = reg_pc;
      ADDR_SP:  base = reg_sp;
      ADDR_HL:  base = reg_hl;
      ADDR_BC:  base = reg_bc;
      ADDR_DE:  base = reg_de;
      ADDR_WZ:  base = reg_wz;
      ADDR_FFC: base = {8'hFF, reg_bc[7:0]};
      ADDR_FFZ: base = {8'hFF, reg_wz[7:0]};
    endcase
  end

  // A same-edge writeback to this pair beats the stale register value
  always_comb begin
    addr = base;
    if (byp_valid && (byp_dst == sel))
      addr = byp_data;
  end

endmodule

// File: rtl/gb_cpu_bus_ctrl.sv
// M-cycle bus sequencer: T1..T4 phase counter, request latch, IDU drive, writeback.
// Optional GB_CPU_DMA_LOCK_EN blocks non-HRAM bus access while DMA runs.
module gb_cpu_bus_ctrl
  import gb_cpu_common_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
`ifdef GB_CPU_DMA_LOCK_EN
  input  logic             dma_active,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  addr_src_t        req_addr_sel,
  input  idu_opcode_t      req_idu_op,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [7:0]       req_wdata,
  input  logic             req_wb_en,
  input  addr_src_t        req_wb_dst,
  input  logic [15:0]      reg_pc,
  input  logic [15:0]      reg_sp,
  input  logic [15:0]      reg_hl,
  input  logic [15:0]      reg_bc,
  input  logic [15:0]      reg_de,
  input  logic [15:0]      reg_wz,
  output idu_instruction_t idu_instr,
  input  logic [15:0]      idu_result,
  output logic             wb_valid,
  output addr_src_t        wb_dst,
  output logic [15:0]      wb_data,
  output logic [15:0]      bus_addr,
  output logic             bus_rd,
  output logic             bus_wr,
  output logic [7:0]       bus_wdata,
  input  logic [7:0]       bus_rdata,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic [1:0]       phase
);

  tcycle_t     phase_q;
  tcycle_t     phase_d;
  mcycle_t     cur_q;
  bus_req_t    req;
  logic [15:0] mux_addr;
  logic        accept;
  logic        lock_d;
  logic        wb_legal;
  logic [7:0]  rdata_q;
  logic [15:0] wb_data_q;

  assign req = '{
    valid:    req_valid,
    addr_sel: req_addr_sel,
    idu_op:   req_idu_op,
    rd:       req_rd,
    wr:       req_wr,
    wdata:    req_wdata,
    wb_en:    req_wb_en,
    wb_dst:   req_wb_dst
  };

  gb_cpu_addr_mux u_addr_mux (
    .sel       (req.addr_sel),
    .reg_pc    (reg_pc),
    .reg_sp    (reg_sp),
    .reg_hl    (reg_hl),
    .reg_bc    (reg_bc),
    .reg_de    (reg_de),
    .reg_wz    (reg_wz),
    .byp_valid (wb_valid),
    .byp_dst   (wb_dst),
    .byp_data  (wb_data),
    .addr      (mux_addr)
  );

`ifdef GB_CPU_DMA_LOCK_EN
  assign lock_d = dma_active && (mux_addr < HRAM_BASE);
`else
  assign lock_d = 1'b0;
`endif

  assign accept   = req.valid && req_ready;
  assign wb_legal = cur_q.wb_en && !is_ff_page(cur_q.wb_dst);

  // Phase state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase_q <= T1;
    else
      phase_q <= phase_d;
  end

  // Free-running T-cycle sequence, no stall
  always_comb begin
    phase_d = T1;
    unique case (phase_q)
      T1: phase_d = T2;
      T2: phase_d = T3;
      T3: phase_d = T4;
      T4: phase_d = T1;
    endcase
  end

  // Phase-decoded strobes from the latched M-cycle
  always_comb begin
    req_ready   = 1'b0;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    rdata_valid = 1'b0;
    wb_valid    = 1'b0;
    unique case (phase_q)
      T1: begin
        bus_rd = cur_q.rd && !cur_q.lock;
      end
      T2, T3: begin
        bus_rd = cur_q.rd && !cur_q.lock;
        bus_wr = cur_q.wr && !cur_q.rd && !cur_q.lock;
      end
      T4: begin
        req_ready   = 1'b1;
        rdata_valid = cur_q.rd;
        wb_valid    = wb_legal;
      end
    endcase
  end

  // Latch a new request leaving T4, else fall to an idle M-cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= MC_RESET;
    end else if (phase_q == T4) begin
      if (accept) begin
        cur_q.addr   <= mux_addr;
        cur_q.op     <= req.idu_op;
        cur_q.rd     <= req.rd;
        cur_q.wr     <= req.wr;
        cur_q.wdata  <= req.wdata;
        cur_q.wb_en  <= req.wb_en;
        cur_q.wb_dst <= req.wb_dst;
        cur_q.lock   <= lock_d;
      end else begin
        cur_q.op    <= IDU_NOP;
        cur_q.rd    <= 1'b0;
        cur_q.wr    <= 1'b0;
        cur_q.wb_en <= 1'b0;
        cur_q.lock  <= 1'b0;
      end
    end
  end

  // Capture read byte and IDU result leaving T3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= 8'h00;
      wb_data_q <= 16'h0000;
    end else if (phase_q == T3) begin
      if (cur_q.rd)
        rdata_q <= cur_q.lock ? 8'hFF : bus_rdata;
      if (wb_legal)
        wb_data_q <= idu_result;
    end
  end

  assign idu_instr = '{opcode: cur_q.op, operand: cur_q.addr};
  assign bus_addr  = cur_q.addr;
  assign bus_wdata = cur_q.wdata;
  assign wb_dst    = cur_q.wb_dst;
  assign wb_data   = wb_data_q;
  assign rdata     = rdata_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
// Directed bench for gb_cpu_bus_ctrl: vector table of M-cycles plus
// hand-written idle and mid-cycle reset sequences.
module tb_gb_cpu_bus_ctrl;
  import gb_cpu_common_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  addr_src_t        req_addr_sel;
  idu_opcode_t      req_idu_op;
  logic             req_rd;
  logic             req_wr;
  logic [7:0]       req_wdata;
  logic             req_wb_en;
  addr_src_t        req_wb_dst;
  logic [15:0]      reg_pc, reg_sp, reg_hl, reg_bc, reg_de, reg_wz;
  idu_instruction_t idu_instr;
  logic [15:0]      idu_result;
  logic             wb_valid;
  addr_src_t        wb_dst;
  logic [15:0]      wb_data;
  logic [15:0]      bus_addr;
  logic             bus_rd;
  logic             bus_wr;
  logic [7:0]       bus_wdata;
  logic [7:0]       bus_rdata;
  logic [7:0]       rdata;
  logic             rdata_valid;
  logic [1:0]       phase;

  int checks = 0;
  int errors = 0;

  gb_cpu_bus_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef GB_CPU_DMA_LOCK_EN
    .dma_active   (1'b0),
`endif
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr_sel (req_addr_sel),
    .req_idu_op   (req_idu_op),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_wdata    (req_wdata),
    .req_wb_en    (req_wb_en),
    .req_wb_dst   (req_wb_dst),
    .reg_pc       (reg_pc),
    .reg_sp       (reg_sp),
    .reg_hl       (reg_hl),
    .reg_bc       (reg_bc),
    .reg_de       (reg_de),
    .reg_wz       (reg_wz),
    .idu_instr    (idu_instr),
    .idu_result   (idu_result),
    .wb_valid     (wb_valid),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data),
    .bus_addr     (bus_addr),
    .bus_rd       (bus_rd),
    .bus_wr       (bus_wr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .phase        (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External IDU model
  always_comb begin
    idu_result = idu_instr.operand;
    if (idu_instr.opcode == IDU_INC)
      idu_result = idu_instr.operand + 16'd1;
    else if (idu_instr.opcode == IDU_DEC)
      idu_result = idu_instr.operand - 16'd1;
  end

  typedef struct {
    addr_src_t   sel;
    idu_opcode_t op;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic        wb_en;
    addr_src_t   wb_dst;
    logic [7:0]  rdin;
    logic [15:0] e_addr;
    logic [3:0]  e_rd;
    logic [3:0]  e_wr;
    logic        e_rv;
    logic [7:0]  e_rdata;
    logic        e_wbv;
    logic [15:0] e_wbdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_t4();
    int budget = 16;
    while (phase != 2'd3 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_t4_timeout", 32'(phase), 32'd3);
  endtask

  task automatic drive(input vec_t v);
    req_addr_sel = v.sel;
    req_idu_op   = v.op;
    req_rd       = v.rd;
    req_wr       = v.wr;
    req_wdata    = v.wdata;
    req_wb_en    = v.wb_en;
    req_wb_dst   = v.wb_dst;
    bus_rdata    = v.rdin;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  function automatic vec_t mk(
    addr_src_t sel, idu_opcode_t op, logic rd, logic wr,
    logic [7:0] wdata, logic wb_en, addr_src_t wb_dst,
    logic [7:0] rdin, logic [15:0] e_addr, logic [3:0] e_rd,
    logic [3:0] e_wr, logic e_rv, logic [7:0] e_rdata,
    logic e_wbv, logic [15:0] e_wbdata);
    vec_t v;
    v.sel = sel; v.op = op; v.rd = rd; v.wr = wr;
    v.wdata = wdata; v.wb_en = wb_en; v.wb_dst = wb_dst;
    v.rdin = rdin; v.e_addr = e_addr; v.e_rd = e_rd;
    v.e_wr = e_wr; v.e_rv = e_rv; v.e_rdata = e_rdata;
    v.e_wbv = e_wbv; v.e_wbdata = e_wbdata;
    return v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_addr"}, 32'(bus_addr), 32'h0);
    chk({tag, "_rd"}, 32'(bus_rd), 32'd0);
    chk({tag, "_wr"}, 32'(bus_wr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus_wdata), 32'h0);
    chk({tag, "_idu"}, 32'(idu_instr), 32'h0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wbdst"}, 32'(wb_dst), 32'd0);
    chk({tag, "_wbdata"}, 32'(wb_data), 32'h0);
    chk({tag, "_rdata"}, 32'(rdata), 32'h0);
    chk({tag, "_rv"}, 32'(rdata_valid), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr_sel = ADDR_PC;
    req_idu_op = IDU_NOP;
    req_rd = 1'b0;
    req_wr = 1'b0;
    req_wdata = 8'h00;
    req_wb_en = 1'b0;
    req_wb_dst = ADDR_PC;
    bus_rdata = 8'h00;
    reg_pc = 16'h0150;
    reg_sp = 16'h0000;
    reg_hl = 16'hC000;
    reg_bc = 16'h1244;
    reg_de = 16'hD0D0;
    reg_wz = 16'h8899;

    vecs[0] = mk(ADDR_PC, IDU_INC, 1, 0, 8'h00, 1, ADDR_PC, 8'h3E,
                 16'h0150, 4'b0111, 4'b0000, 1, 8'h3E, 1, 16'h0151);
    vecs[1] = mk(ADDR_FFC, IDU_NOP, 0, 1, 8'hA5, 1, ADDR_FFC, 8'h00,
                 16'hFF44, 4'b0000, 4'b0110, 0, 8'h3E, 0, 16'h0151);
    vecs[2] = mk(ADDR_HL, IDU_INC, 0, 0, 8'h00, 1, ADDR_HL, 8'h00,
                 16'hC000, 4'b0000, 4'b0000, 0, 8'h3E, 1, 16'hC001);
    vecs[3] = mk(ADDR_HL, IDU_INC, 0, 0, 8'h00, 1, ADDR_HL, 8'h00,
                 16'hC001, 4'b0000, 4'b0000, 0, 8'h3E, 1, 16'hC002);
    vecs[4] = mk(ADDR_SP, IDU_DEC, 0, 0, 8'h00, 1, ADDR_SP, 8'h00,
                 16'h0000, 4'b0000, 4'b0000, 0, 8'h3E, 1, 16'hFFFF);
    vecs[5] = mk(ADDR_DE, IDU_NOP, 1, 1, 8'hC3, 0, ADDR_PC, 8'h77,
                 16'hD0D0, 4'b0111, 4'b0000, 1, 8'h77, 0, 16'hFFFF);
    vecs[6] = mk(ADDR_FFZ, IDU_INC, 1, 0, 8'h00, 1, ADDR_FFZ, 8'h5A,
                 16'hFF99, 4'b0111, 4'b0000, 1, 8'h5A, 0, 16'hFFFF);
    vecs[7] = mk(ADDR_WZ, IDU_DEC, 0, 0, 8'h00, 1, ADDR_HL, 8'h00,
                 16'h8899, 4'b0000, 4'b0000, 0, 8'h5A, 1, 16'h8898);
    vecs[8] = mk(ADDR_HL, IDU_NOP, 0, 0, 8'h00, 0, ADDR_PC, 8'h00,
                 16'h8898, 4'b0000, 4'b0000, 0, 8'h5A, 0, 16'h8898);

    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    chk("idle_phase_0", 32'(phase), 32'd0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("idle_phase_%0d", i), 32'(phase), 32'(i % 4));
      chk($sformatf("idle_strb_%0d", i),
          32'({bus_rd, bus_wr, wb_valid}), 32'd0);
      chk($sformatf("idle_addr_%0d", i), 32'(bus_addr), 32'h0);
    end

    for (int i = 0; i < 9; i++) begin
      wait_t4();
      drive(vecs[i]);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d_t%0d_phase", i, k), 32'(phase), 32'(k));
        chk($sformatf("v%0d_t%0d_addr", i, k), 32'(bus_addr),
            32'(vecs[i].e_addr));
        chk($sformatf("v%0d_t%0d_idu", i, k), 32'(idu_instr),
            32'({vecs[i].op, vecs[i].e_addr}));
        chk($sformatf("v%0d_t%0d_rd", i, k), 32'(bus_rd),
            32'(vecs[i].e_rd[k]));
        chk($sformatf("v%0d_t%0d_wr", i, k), 32'(bus_wr),
            32'(vecs[i].e_wr[k]));
        chk($sformatf("v%0d_t%0d_ready", i, k), 32'(req_ready),
            32'(k == 3));
        if (vecs[i].wr && !vecs[i].rd)
          chk($sformatf("v%0d_t%0d_wdata", i, k), 32'(bus_wdata),
              32'(vecs[i].wdata));
      end
      chk($sformatf("v%0d_rv", i), 32'(rdata_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
      chk($sformatf("v%0d_wbv", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
      if (vecs[i].e_wbv) begin
        chk($sformatf("v%0d_wbdata", i), 32'(wb_data),
            32'(vecs[i].e_wbdata));
        chk($sformatf("v%0d_wbdst", i), 32'(wb_dst),
            32'(vecs[i].wb_dst));
      end
    end

    // No request accepted: idle M-cycle holds the address
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("nop_t%0d_addr", k), 32'(bus_addr), 32'h8898);
      chk($sformatf("nop_t%0d_op", k), 32'(idu_instr.opcode),
          32'(IDU_NOP));
      chk($sformatf("nop_t%0d_strb", k),
          32'({bus_rd, bus_wr, wb_valid, rdata_valid}), 32'd0);
    end

    // Reset asserted in T2 of a read
    wait_t4();
    drive(mk(ADDR_PC, IDU_INC, 1, 0, 8'h00, 1, ADDR_PC, 8'h11,
             16'h0150, 4'b0111, 4'b0000, 1, 8'h11, 1, 16'h0151));
    @(negedge clk);
    @(negedge clk);
    chk("mrst_pre_phase", 32'(phase), 32'd1);
    chk("mrst_pre_rd", 32'(bus_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_rel_phase", 32'(phase), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mrst_t%0d_phase", k), 32'(phase), 32'(k));
      chk($sformatf("mrst_t%0d_strb", k),
          32'({bus_rd, wb_valid, rdata_valid}), 32'd0);
    end
    chk("mrst_ready", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
